// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the 3x3 convolution sequencer.
// State encoding and output-geometry helpers used by the top and its bench.
package conv_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD_W = S_LOAD_W,
        ST_RUN    = S_RUN,
        ST_DRAIN  = S_DRAIN,
        ST_DONE   = S_DONE
    } state_e;

    // A valid 3x3 window needs two extra pixels beyond its top-left corner.
    function automatic int out_dim(input int img_dim);
        return img_dim - 2;
    endfunction

    function automatic int n_out(input int img_w, input int img_h);
        return out_dim(img_w) * out_dim(img_h);
    endfunction

endpackage

// File: rtl/conv3x3_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and the
// window source / datapath side (slave).
interface conv3x3_seq_ctrl_if #(parameter int AW = 8);
    logic          start;
    logic          src_ready;
    logic          busy;
    logic          done;
    logic          wb_write_en;
    logic          win_valid;
    logic [AW-1:0] win_row;
    logic [AW-1:0] win_col;
    logic          psum_valid;
    logic [AW-1:0] psum_row;
    logic [AW-1:0] psum_col;
    logic          psum_last;

    modport master (
        input  start, src_ready,
        output busy, done, wb_write_en, win_valid, win_row, win_col,
               psum_valid, psum_row, psum_col, psum_last
    );

    modport slave (
        output start, src_ready,
        input  busy, done, wb_write_en, win_valid, win_row, win_col,
               psum_valid, psum_row, psum_col, psum_last
    );
endinterface

// File: rtl/conv3x3_seq_ctrl_tag_delay_line.sv
// Fixed-latency tag shift register; the MSB of each stage is its valid bit,
// exposed per stage so the owner can tell when the line is empty.
module tag_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [DEPTH-1:0] vld_taps
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    always_comb begin
        vld_taps = '0;
        for (int i = 0; i < DEPTH; i++) vld_taps[i] = stage_q[i][WIDTH-1];
    end

    assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/conv3x3_seq_ctrl.sv
// Layer sequencer: weight load strobe, raster window issue, coordinate
// tagging of datapath results through a matched delay line, done on drain.
module conv3x3_seq_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int PIPE_LAT = 2,
    parameter int AW       = 8
) (
    input  logic               clk,
    input  logic               rst,
    conv3x3_seq_ctrl_if.master bus
);
    localparam int OUT_W = out_dim(IMG_W);
    localparam int OUT_H = out_dim(IMG_H);
    localparam int TAG_W = 2 + 2*AW;
    localparam logic [AW-1:0] COL_MAX = AW'(OUT_W - 1);
    localparam logic [AW-1:0] ROW_MAX = AW'(OUT_H - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] row_q, row_d, col_q, col_d;
    logic          issue, last_issue, pipe_busy;
    logic [TAG_W-1:0]    tag_in, tag_out;
    logic [PIPE_LAT-1:0] vld_taps;

    assign last_issue = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign pipe_busy  = |vld_taps;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d = ST_LOAD_W;
                row_d   = '0;
                col_d   = '0;
            end
            ST_LOAD_W: state_d = ST_RUN;
            ST_RUN: begin
                // Source readiness gates issue only; the datapath keeps moving.
                issue = bus.src_ready;
                if (issue) begin
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + AW'(1);
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                    if (last_issue) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (!pipe_busy) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign tag_in = {issue, issue && last_issue, row_q, col_q};

    tag_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(TAG_W)) u_tags (
        .clk      (clk),
        .rst      (rst),
        .din      (tag_in),
        .dout     (tag_out),
        .vld_taps (vld_taps)
    );

    assign bus.busy        = (state_q == ST_LOAD_W) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.wb_write_en = (state_q == ST_LOAD_W);
    assign bus.win_valid   = issue;
    assign bus.win_row     = row_q;
    assign bus.win_col     = col_q;
    assign {bus.psum_valid, bus.psum_last, bus.psum_row, bus.psum_col} = tag_out;
endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// Bench for conv3x3_seq_ctrl: 5x5 and 3x3 instances checked cycle by cycle
// against a per-layer timeline model built from window counts and latencies.
module tb_conv3x3_seq_ctrl;
    localparam int AW   = 8;
    localparam int LAT  = 2;
    localparam int MAXC = 160;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv3x3_seq_ctrl_if #(.AW(AW)) ifa ();
    conv3x3_seq_ctrl_if #(.AW(AW)) ifb ();

    conv3x3_seq_ctrl #(.IMG_W(5), .IMG_H(5), .PIPE_LAT(LAT), .AW(AW)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master));
    conv3x3_seq_ctrl #(.IMG_W(3), .IMG_H(3), .PIPE_LAT(LAT), .AW(AW)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master));

    int n_cmp = 0;
    int n_fail = 0;

    bit            st[MAXC], rdy[MAXC];
    bit            e_busy[MAXC], e_done[MAXC], e_wb[MAXC], e_wv[MAXC], e_pv[MAXC], e_pl[MAXC];
    logic [AW-1:0] e_row[MAXC], e_col[MAXC], e_prow[MAXC], e_pcol[MAXC];
    int            obs_done_cyc, obs_done_n, obs_pv_n;

    task automatic clear_model();
        for (int i = 0; i < MAXC; i++) begin
            st[i] = 0; rdy[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_wb[i] = 0; e_wv[i] = 0; e_pv[i] = 0; e_pl[i] = 0;
            e_row[i] = '0; e_col[i] = '0; e_prow[i] = '0; e_pcol[i] = '0;
        end
    endtask

    // One layer started at cycle s: window k goes out on the k-th ready cycle
    // from s+2, its result appears LAT later, done two cycles after the last result.
    task automatic model_layer(input int w, input int h, input int s, output int done_c);
        int ow, n, k, c, lastc;
        ow = w - 2; n = (w - 2) * (h - 2); k = 0; c = s + 2; lastc = c;
        e_wb[s+1] = 1;
        while (k < n && c < MAXC - 8) begin
            if (rdy[c]) begin
                e_wv[c] = 1;
                e_row[c] = AW'(k / ow); e_col[c] = AW'(k % ow);
                e_pv[c+LAT] = 1;
                e_prow[c+LAT] = AW'(k / ow); e_pcol[c+LAT] = AW'(k % ow);
                lastc = c;
                k++;
            end
            c++;
        end
        e_pl[lastc+LAT] = 1;
        done_c = lastc + LAT + 2;
        for (int i = s + 1; i < done_c; i++) e_busy[i] = 1;
        e_done[done_c] = 1;
    endtask

    task automatic run_cycles(input bit use_b, input int ncyc);
        logic [5:0] f, ef;
        logic [AW-1:0] wr, wc, pr, pc;
        obs_done_cyc = -1; obs_done_n = 0; obs_pv_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (use_b) begin ifb.start = st[c]; ifb.src_ready = rdy[c]; end
            else       begin ifa.start = st[c]; ifa.src_ready = rdy[c]; end
            @(negedge clk);
            if (use_b) begin
                f = {ifb.busy, ifb.done, ifb.wb_write_en, ifb.win_valid, ifb.psum_valid, ifb.psum_last};
                wr = ifb.win_row; wc = ifb.win_col; pr = ifb.psum_row; pc = ifb.psum_col;
            end else begin
                f = {ifa.busy, ifa.done, ifa.wb_write_en, ifa.win_valid, ifa.psum_valid, ifa.psum_last};
                wr = ifa.win_row; wc = ifa.win_col; pr = ifa.psum_row; pc = ifa.psum_col;
            end
            ef = {e_busy[c], e_done[c], e_wb[c], e_wv[c], e_pv[c], e_pl[c]};
            n_cmp++;
            if (f !== ef) begin
                n_fail++;
                $display("FAIL flags cyc=%0d got=%b exp=%b (busy,done,wb,wv,pv,plast)", c, f, ef);
            end
            if (ef[2]) begin
                n_cmp++;
                if ({wr, wc} !== {e_row[c], e_col[c]}) begin
                    n_fail++;
                    $display("FAIL win_coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", c, wr, wc, e_row[c], e_col[c]);
                end
            end
            if (ef[1]) begin
                n_cmp++;
                if ({pr, pc} !== {e_prow[c], e_pcol[c]}) begin
                    n_fail++;
                    $display("FAIL psum_coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", c, pr, pc, e_prow[c], e_pcol[c]);
                end
            end
            if (f[4]) begin obs_done_n++; if (obs_done_cyc < 0) obs_done_cyc = c; end
            if (f[1]) obs_pv_n++;
        end
        ifa.start = 0; ifa.src_ready = 0; ifb.start = 0; ifb.src_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; ifa.start = 0; ifa.src_ready = 0; ifb.start = 0; ifb.src_ready = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ifa.busy, ifa.done, ifa.wb_write_en, ifa.win_valid, ifa.win_row, ifa.win_col,
             ifa.psum_valid, ifa.psum_row, ifa.psum_col, ifa.psum_last} !== '0) begin
            n_fail++; $display("FAIL reset_a outputs not all zero busy=%b wv=%b pv=%b", ifa.busy, ifa.win_valid, ifa.psum_valid);
        end
        n_cmp++;
        if ({ifb.busy, ifb.done, ifb.wb_write_en, ifb.win_valid, ifb.win_row, ifb.win_col,
             ifb.psum_valid, ifb.psum_row, ifb.psum_col, ifb.psum_last} !== '0) begin
            n_fail++; $display("FAIL reset_b outputs not all zero busy=%b wv=%b pv=%b", ifb.busy, ifb.win_valid, ifb.psum_valid);
        end
        rst = 0;
    endtask

    task automatic check_layer(input string name, input int exp_done, input int exp_pv);
        n_cmp++;
        if (obs_done_cyc != exp_done) begin
            n_fail++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, obs_done_cyc, exp_done);
        end
        n_cmp++;
        if (obs_pv_n != exp_pv) begin
            n_fail++; $display("FAIL %s psum_count got=%0d exp=%0d", name, obs_pv_n, exp_pv);
        end
    endtask

    task automatic test_basic();
        int d;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = 1;
        st[0] = 1;
        model_layer(5, 5, 0, d);
        run_cycles(0, d + 4);
        check_layer("basic", 14, 9);
    endtask

    task automatic test_stall();
        int d;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = (i != 4 && i != 5);
        st[0] = 1;
        model_layer(5, 5, 0, d);
        run_cycles(0, d + 4);
        check_layer("stall", 16, 9);
    endtask

    task automatic test_random_ready();
        int d;
        for (int it = 0; it < 4; it++) begin
            clear_model();
            for (int i = 0; i < MAXC; i++) rdy[i] = (i >= 60) || ($urandom_range(0, 3) != 0);
            st[0] = 1;
            model_layer(5, 5, 0, d);
            run_cycles(0, d + 4);
            check_layer("random_ready", d, 9);
        end
    endtask

    task automatic test_start_held();
        int d;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = (i >= 60) || ($urandom_range(0, 1) != 0);
        model_layer(5, 5, 0, d);
        for (int i = 0; i <= d; i++) st[i] = 1;
        run_cycles(0, d + 6);
        n_cmp++;
        if (obs_done_n != 1) begin
            n_fail++; $display("FAIL start_held done_pulses got=%0d exp=1", obs_done_n);
        end
    endtask

    task automatic test_mid_reset();
        int d;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = 1;
        st[0] = 1;
        model_layer(5, 5, 0, d);
        run_cycles(0, 6);
        @(posedge clk); #1;
        ifa.src_ready = 1;
        #1 rst = 1;
        #1;
        n_cmp++;
        if ({ifa.busy, ifa.done, ifa.wb_write_en, ifa.win_valid, ifa.win_row, ifa.win_col,
             ifa.psum_valid, ifa.psum_row, ifa.psum_col, ifa.psum_last} !== '0) begin
            n_fail++; $display("FAIL mid_reset outputs busy=%b wv=%b row=%0d col=%0d pv=%b", ifa.busy, ifa.win_valid, ifa.win_row, ifa.win_col, ifa.psum_valid);
        end
        ifa.src_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ifa.done, ifa.busy} !== 2'b00) begin
                n_fail++; $display("FAIL mid_reset_hold cyc=%0d done=%b busy=%b exp=0,0", i, ifa.done, ifa.busy);
            end
        end
        rst = 0;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = 1;
        st[0] = 1;
        model_layer(5, 5, 0, d);
        run_cycles(0, d + 4);
        check_layer("after_reset", 14, 9);
    endtask

    task automatic test_small();
        int d;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = 1;
        st[0] = 1;
        model_layer(3, 3, 0, d);
        run_cycles(1, d + 4);
        check_layer("small_3x3", 6, 1);
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        clear_model();
        for (int i = 0; i < MAXC; i++) rdy[i] = (i >= 50 && i < 70) || (i >= 110) || ($urandom_range(0, 3) != 0);
        st[0] = 1;
        model_layer(5, 5, 0, d1);
        st[d1+1] = 1;
        model_layer(5, 5, d1 + 1, d2);
        run_cycles(0, d2 + 4);
        n_cmp++;
        if (obs_done_n != 2) begin
            n_fail++; $display("FAIL back_to_back done_pulses got=%0d exp=2", obs_done_n);
        end
        n_cmp++;
        if (obs_pv_n != 18) begin
            n_fail++; $display("FAIL back_to_back psum_count got=%0d exp=18", obs_pv_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random_ready();
        test_start_held();
        test_mid_reset();
        test_small();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/conv3x3_seq_ctrl.md
Name: conv3x3_seq_ctrl

Overview:
- Sequencer for the 3x3 convolution tensor datapath: weight buffer, then PE kernel, then accumulator.
- On a start pulse it:
  - loads the filter into the weight buffer with a one-cycle write strobe;
  - streams every valid 3x3 ifmap window of an IMG_H x IMG_W feature map in raster order;
  - tags each result emerging from the datapath with its output coordinate;
  - pulses done once the pipeline has drained.
- Sits between the ifmap window source (line buffer/SRAM) and the tensor datapath, and drives its weight-buffer write enable.

Parameters:
- IMG_W, 8, feature-map width in pixels (min 3).
- IMG_H, 8, feature-map height in pixels (min 3).
- PIPE_LAT, 2, cycles from window presented on ifmap to matching psumOut valid (kernel reg + accumulator reg).
- AW, 8, width of row/col coordinate outputs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer; sampled only in IDLE.
- src_ready  in  1  window source can present the window at win_row/win_col this cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of layer.
- wb_write_en  out  1  weight-buffer write strobe; filter must be valid on the same cycle.
- win_valid  out  1  window issued this cycle; source drives ifmap for (win_row, win_col).
- win_row  out  AW  top-left row of current window.
- win_col  out  AW  top-left col of current window.
- psum_valid  out  1  psumOut corresponds to a real window this cycle.
- psum_row  out  AW  output coordinate of psumOut.
- psum_col  out  AW  output coordinate of psumOut.
- psum_last  out  1  qualifies psum_valid for the final output of the layer.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, delay line cleared. Asynchronous; a reset mid-layer aborts it with no done pulse.
- States: IDLE, LOAD_W, RUN, DRAIN, DONE.
- IDLE:
  - start=1: go to LOAD_W; clear row/col.
  - start while not IDLE is ignored.
- LOAD_W: wb_write_en=1 for exactly this cycle, then go to RUN. filter_out is valid from the next cycle.
- RUN:
  - win_valid = src_ready; the window is presented and issued the same cycle.
  - On issue: col increments. At col = IMG_W-3, col wraps to 0 and row increments.
  - On issue of (IMG_H-3, IMG_W-3): go to DRAIN.
  - src_ready=0: coordinates hold, win_valid=0. A bubble enters the delay line; the datapath itself is never stalled.
- Delay line: PIPE_LAT stages of {valid, row, col, last}, advancing every cycle. Its outputs are psum_valid/psum_row/psum_col/psum_last. A window issued in cycle t yields psum_valid in cycle t+PIPE_LAT.
- DRAIN: wait until the delay line holds no valid entry, i.e. the cycle after psum_last is seen. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE. start in the DONE cycle is ignored.
- Total issues per layer: (IMG_H-2)*(IMG_W-2). Exactly that many psum_valid pulses, with psum_last on the final one only.
- busy is 1 in LOAD_W, RUN and DRAIN; 0 in IDLE and DONE.
- Coordinates are unsigned, compared against localparam limits. AW must cover IMG_W-3 and IMG_H-3.

Decomposition:
- Package conv_ctrl_pkg holds:
  - state encoding localparams (IDLE=0, LOAD_W=1, RUN=2, DRAIN=3, DONE=4, 3-bit);
  - derived constants OUT_W=IMG_W-2, OUT_H=IMG_H-2, N_OUT=OUT_W*OUT_H.
- One sub-module, tag_delay_line: parameterised shift register (DEPTH, WIDTH) with async reset, carrying the {valid, last, row, col} tag.

Test Plan:
- IMG_W=IMG_H=5, PIPE_LAT=2, src_ready=1, start pulse at cycle 0:
  - wb_write_en high at cycle 1 only;
  - win_valid cycles 2-10 with (row,col) = (0,0),(0,1),(0,2),(1,0)...(2,2);
  - psum_valid cycles 4-12, psum_last at cycle 12;
  - done at cycle 14; busy cycles 1-13.
- Same config, src_ready low at cycles 4-5:
  - coordinates hold at (0,2);
  - psum_valid low at cycles 6-7;
  - 9 psum_valid total, done at cycle 16.
- start held high for the whole run: exactly one layer; no re-launch until IDLE is re-entered and start is sampled again.
- rst asserted at cycle 6 of a run: all outputs 0 immediately (asynchronous), no done pulse; a subsequent start runs a full clean layer of 9 outputs.
- IMG_W=IMG_H=3: single window (0,0), psum_last on the only psum_valid, done two cycles after it.
- Back-to-back layers: start in the cycle after DONE is accepted; second layer reproduces the first layer's timing exactly, offset by its start cycle.
